// File: rtl/comm_pkg.sv
// Shared types and defaults for the CommMaster command link receive path.
package comm_pkg;

  localparam int unsigned DEF_BAUD_DIV = 2604;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } pair_state_t;

endpackage

// File: rtl/uart_cmd_wrapper_if.sv
// Command hand-off between the UART command wrapper and the command processor.
interface uart_cmd_wrapper_if;

  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;

  modport master (
    output cmd,
    output cmd_rdy,
    input  clr_cmd_rdy
  );

  modport slave (
    input  cmd,
    input  cmd_rdy,
    output clr_cmd_rdy
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start/data/stop FSM, one-cycle rx_rdy.
module uart_rx
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t       state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      data_q, data_d;
  logic            rdy_q, rdy_d;
  logic            tick_c;
  logic            fall_c;

  assign tick_c  = (baud_cnt_q == '0);
  assign fall_c  = rx_prev_q & ~rx_sync_q;
  assign rx_data = data_q;
  assign rx_rdy  = rdy_q;

  // Synchronize the asynchronous line; the third flop gives edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      rdy_q      <= rdy_d;
    end
  end

  // Next-state: counter reaches zero at the middle of each bit.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = tick_c ? baud_cnt_q : baud_cnt_q - CNT_W'(1);
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    rdy_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d    = START;
          baud_cnt_d = CNT_W'(BAUD_DIV / 2);
        end
      end
      START: begin
        if (tick_c) begin
          if (!rx_sync_q) begin
            state_d    = DATA;
            baud_cnt_d = CNT_W'(BAUD_DIV - 1);
            bit_cnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_c) begin
          data_d     = {rx_sync_q, data_q[7:1]};
          baud_cnt_d = CNT_W'(BAUD_DIV - 1);
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          rdy_d   = rx_sync_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// UART command endpoint: pairs received bytes (high first) into a 16-bit command
// with a sticky ready flag. Optional feature macro: CMD_BYTE_TIMEOUT_EN
// (abandons a lone high byte after TMO_BITS bit-times).
module uart_cmd_wrapper
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV,
  parameter int unsigned TMO_BITS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RX,
  uart_cmd_wrapper_if.master  cmd_bus
);

  if (BAUD_DIV < 16 || TMO_BITS == 0) begin : g_param_check
    $error("uart_cmd_wrapper: BAUD_DIV must be >= 16 and TMO_BITS nonzero");
  end

  logic [7:0]  rx_data;
  logic        rx_rdy;

  pair_state_t pair_q, pair_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        tmo_expire_c;

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .rx_data (rx_data),
    .rx_rdy  (rx_rdy)
  );

  assign cmd_bus.cmd     = cmd_q;
  assign cmd_bus.cmd_rdy = cmd_rdy_q;

`ifdef CMD_BYTE_TIMEOUT_EN
  localparam int unsigned TMO_CYC = TMO_BITS * BAUD_DIV;
  localparam int unsigned TMO_W   = $clog2(TMO_CYC);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_expire_c = (pair_q == WAIT_LO) && (tmo_cnt_q == TMO_W'(TMO_CYC - 1));

  // Inter-byte timer runs only while waiting for the low byte.
  always_comb begin
    tmo_cnt_d = '0;
    if (pair_q == WAIT_LO) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  // Timer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_expire_c = 1'b0;
`endif

  // Pairing state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_q    <= WAIT_HI;
      hi_byte_q <= '0;
      cmd_q     <= '0;
      cmd_rdy_q <= 1'b0;
    end else begin
      pair_q    <= pair_d;
      hi_byte_q <= hi_byte_d;
      cmd_q     <= cmd_d;
      cmd_rdy_q <= cmd_rdy_d;
    end
  end

  // Byte pairing; a completed command's set beats any clear in the same cycle.
  always_comb begin
    pair_d    = pair_q;
    hi_byte_d = hi_byte_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (cmd_bus.clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end
    case (pair_q)
      WAIT_HI: begin
        if (rx_rdy) begin
          hi_byte_d = rx_data;
          cmd_rdy_d = 1'b0;
          pair_d    = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          cmd_d     = {hi_byte_q, rx_data};
          cmd_rdy_d = 1'b1;
          pair_d    = WAIT_HI;
        end else if (tmo_expire_c) begin
          hi_byte_d = '0;
          pair_d    = WAIT_HI;
        end
      end
      default: pair_d = WAIT_HI;
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: directed table, corner sequences,
// and random frames against a byte-level pairing model.
module tb_uart_cmd_wrapper;

  localparam int BAUD = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic rx;

  uart_cmd_wrapper_if cmd_bus ();

  uart_cmd_wrapper #(.BAUD_DIV(BAUD), .TMO_BITS(20)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx),
    .cmd_bus (cmd_bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: command pairing seen at the byte level.
  logic [15:0] m_cmd;
  logic        m_rdy;
  logic [7:0]  m_hi;
  bit          m_hv;

  typedef struct packed {
    logic [15:0] cmd;
    logic        clr_first;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cmd = 16'h0000;
    m_rdy = 1'b0;
    m_hi  = 8'h00;
    m_hv  = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (ok) begin
      if (!m_hv) begin
        m_hi  = b;
        m_hv  = 1'b1;
        m_rdy = 1'b0;
      end else begin
        m_cmd = {m_hi, b};
        m_rdy = 1'b1;
        m_hv  = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int idle_bits);
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BAUD);
    end
    rx = stop_ok;
    tick(BAUD);
    rx = 1'b1;
    tick(idle_bits * BAUD);
  endtask

  task automatic send_model(input logic [7:0] b, input bit ok, input int idle_bits);
    send_frame(b, ok, idle_bits);
    model_byte(b, ok);
  endtask

  task automatic pulse_clr();
    cmd_bus.clr_cmd_rdy = 1'b1;
    tick(1);
    cmd_bus.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  task automatic check_model(input string name);
    check({name, "_cmd"}, cmd_bus.cmd, m_cmd);
    check({name, "_rdy"}, 16'(cmd_bus.cmd_rdy), 16'(m_rdy));
  endtask

  initial begin
    int lat;
    int waited;
    logic [7:0] rb;
    bit ok;

    vecs[0] = '{cmd: 16'h5555, clr_first: 1'b0};
    vecs[1] = '{cmd: 16'hFFFF, clr_first: 1'b0};
    vecs[2] = '{cmd: 16'h0000, clr_first: 1'b1};
    vecs[3] = '{cmd: 16'hC3A5, clr_first: 1'b1};
    vecs[4] = '{cmd: 16'h0F0F, clr_first: 1'b0};

    rst_n = 1'b0;
    rx = 1'b1;
    cmd_bus.clr_cmd_rdy = 1'b0;
    model_reset();
    tick(3);
    check("rst_cmd", cmd_bus.cmd, 16'h0000);
    check("rst_rdy", 16'(cmd_bus.cmd_rdy), 16'h0000);
    rst_n = 1'b1;
    tick(2 * BAUD);
    check("idle_rdy", 16'(cmd_bus.cmd_rdy), 16'h0000);

    // Directed command table.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].clr_first) begin
        pulse_clr();
        check("clr_drop", 16'(cmd_bus.cmd_rdy), 16'h0000);
      end
      send_model(vecs[v].cmd[15:8], 1'b1, 1);
      check("hi_rdy", 16'(cmd_bus.cmd_rdy), 16'h0000);
      check("hi_cmd_hold", cmd_bus.cmd, m_cmd);
      send_model(vecs[v].cmd[7:0], 1'b1, 1);
      check("tbl_cmd", cmd_bus.cmd, vecs[v].cmd);
      check("tbl_rdy", 16'(cmd_bus.cmd_rdy), 16'h0001);
      if (v == 0) begin
        tick(10 * BAUD);
        check("hold_cmd", cmd_bus.cmd, 16'h5555);
        check("hold_rdy", 16'(cmd_bus.cmd_rdy), 16'h0001);
      end
    end

    // clr while already clear is harmless.
    pulse_clr();
    pulse_clr();
    check("clr_idle_rdy", 16'(cmd_bus.cmd_rdy), 16'h0000);
    check("clr_idle_cmd", cmd_bus.cmd, 16'h0F0F);

    // Latency from low-byte start edge to cmd_rdy, back-to-back frames.
    send_model(8'h13, 1'b1, 0);
    lat = 0;
    fork
      send_model(8'h57, 1'b1, 1);
      begin
        while (!cmd_bus.cmd_rdy && lat < 300) begin
          tick(1);
          lat++;
        end
      end
    join
    check("latency_ok", 16'(lat >= 150 && lat <= 165), 16'h0001);
    check("b2b_cmd", cmd_bus.cmd, 16'h1357);

    // Consumer clear coincides with low-byte completion.
    send_model(8'hAA, 1'b1, 1);
    waited = 0;
    fork
      send_frame(8'hAA, 1'b1, 1);
      begin
        while (!dut.u_rx.rx_rdy && waited < 400) begin
          tick(1);
          waited++;
        end
        cmd_bus.clr_cmd_rdy = 1'b1;
        tick(1);
        cmd_bus.clr_cmd_rdy = 1'b0;
      end
    join
    model_byte(8'hAA, 1'b1);
    check("sim_clr_seen", 16'(waited < 400), 16'h0001);
    check("sim_clr_rdy", 16'(cmd_bus.cmd_rdy), 16'h0001);
    check("sim_clr_cmd", cmd_bus.cmd, 16'hAAAA);

    // Framing error between high and low byte.
    send_model(8'h00, 1'b1, 1);
    send_model(8'hA5, 1'b0, 2);
    check("frm_rdy_mid", 16'(cmd_bus.cmd_rdy), 16'h0000);
    send_model(8'h2D, 1'b1, 1);
    check("frm_cmd", cmd_bus.cmd, 16'h002D);
    check("frm_rdy", 16'(cmd_bus.cmd_rdy), 16'h0001);

    // Reset during bit 4 of the high byte of 16'h001E.
    rx = 1'b0;
    tick(BAUD);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      tick(BAUD);
    end
    tick(BAUD / 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cmd", cmd_bus.cmd, 16'h0000);
    check("rst_mid_rdy", 16'(cmd_bus.cmd_rdy), 16'h0000);
    rx = 1'b1;
    tick(4);
    rst_n = 1'b1;
    model_reset();
    tick(2 * BAUD);
    send_model(8'h00, 1'b1, 1);
    send_model(8'h1E, 1'b1, 1);
    check("rst_resend_cmd", cmd_bus.cmd, 16'h001E);
    check("rst_resend_rdy", 16'(cmd_bus.cmd_rdy), 16'h0001);

    // Random frames, bad stop bits and clears against the model.
    for (int k = 0; k < 24; k++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) pulse_clr();
      send_model(rb, ok, ok ? int'($urandom_range(0, 2)) : 1);
      check_model("rand");
    end

`ifdef CMD_BYTE_TIMEOUT_EN
    // Lone high byte is abandoned after the inter-byte timeout.
    send_model(8'h12, 1'b1, 0);
    tick(25 * BAUD);
    m_hv = 1'b0;
    send_model(8'h34, 1'b1, 1);
    send_model(8'h56, 1'b1, 1);
    check("tmo_cmd", cmd_bus.cmd, 16'h3456);
    check("tmo_rdy", 16'(cmd_bus.cmd_rdy), 16'h0001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_wrapper.md
# uart_cmd_wrapper

Receive-side endpoint of the CommMaster command link inside MazeRunner. Deserializes 8N1 UART frames on `RX` and assembles each pair of bytes, high byte first, into one 16-bit travel-plan command. Presents that command to the command processor with a sticky `cmd_rdy` flag that the processor clears once it has consumed the command. Contains its own UART receiver sub-module; the byte-pairing FSM and the output registers sit in this block.

## Interface
- `BAUD_DIV`, default 2604: clocks per bit (19200 baud at 50 MHz); must be ≥ 16.
- `TMO_BITS`, default 20: inter-byte timeout in bit-times; used only with `CMD_BYTE_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `RX` in 1: serial line from CommMaster; idles high; asynchronous to `clk`.
- `clr_cmd_rdy` in 1: one-cycle pulse from the consumer; clears `cmd_rdy`.
- `cmd` out 16: last complete command; updated atomically.
- `cmd_rdy` out 1: sticky flag; a new command is valid on `cmd`.

## Operation
- Reset values: `cmd` = 16'h0000, `cmd_rdy` = 0, pairing FSM = `WAIT_HI`, receiver idle.
- Synchronizer:
  - `RX` is passed through two flops, both reset to 1.
  - All receiver logic uses the synchronized copy only.
- Receiver FSM:
  - `IDLE`: a synchronized falling edge moves to `START` and loads the bit counter with `BAUD_DIV/2`.
  - `START`: at mid-bit, if the line is still 0, go to `DATA`; otherwise treat it as a glitch and return to `IDLE`.
  - `DATA`: sample 8 bits at `BAUD_DIV` intervals, LSB first.
  - `STOP`: sample the stop bit. If it is 1, pulse `rx_rdy` for one cycle with `rx_data`. If it is 0 (framing error), drop the byte with no pulse. Either way, return to `IDLE`.
- Pairing FSM:
  - `WAIT_HI` + `rx_rdy`: store `rx_data` in the staging register `hi_byte`, clear `cmd_rdy`, go to `WAIT_LO`.
  - `WAIT_LO` + `rx_rdy`: load `cmd` = {`hi_byte`, `rx_data`}, set `cmd_rdy`, go to `WAIT_HI`.
  - `cmd` never shows a half-updated value; `hi_byte` is internal.
- `cmd_rdy` precedence, highest first: set (low byte accepted), then clear (high byte accepted or `clr_cmd_rdy`), then hold.
  - `clr_cmd_rdy` and low-byte completion in the same cycle leaves `cmd_rdy` = 1.
- `clr_cmd_rdy` while `cmd_rdy` = 0 has no effect.
- A framing error on the low byte does not reset pairing. The next good byte completes the command.

## Timing
- `rx_rdy` asserts about (2 + 9.5·`BAUD_DIV`) clocks after the start-bit falling edge on `RX`: 2 synchronizer clocks, then half a bit to mid-start, then 9 whole bits to mid-stop.
- `cmd` and `cmd_rdy` update on the clock edge after the `rx_rdy` cycle, i.e. 1-cycle latency.
- Back-to-back frames: the receiver is re-armed in `IDLE` from mid-stop, so a start bit that follows immediately is caught.
- Reset mid-frame: all state clears asynchronously. After release, any partial frame in flight is resynchronized at the next falling edge.
- The bit counter is sized to hold `BAUD_DIV`-1 and does not wrap within a bit.

## Configuration
- `CMD_BYTE_TIMEOUT_EN` defined:
  - In `WAIT_LO`, a counter runs for `TMO_BITS`·`BAUD_DIV` clocks, measured from the high byte's `rx_rdy`.
  - On expiry, `hi_byte` is discarded and the FSM returns to `WAIT_HI`; `cmd` and `cmd_rdy` are unchanged.
  - The counter restarts on every entry to `WAIT_LO`.
- `CMD_BYTE_TIMEOUT_EN` undefined: there is no counter, and `WAIT_LO` waits indefinitely.

## Structure
- Shared package `comm_pkg`:
  - typedef `rx_state_t` {`IDLE`, `START`, `DATA`, `STOP`}.
  - typedef `pair_state_t` {`WAIT_HI`, `WAIT_LO`}.
  - `localparam` `DEF_BAUD_DIV` = 2604.
- Sub-module `uart_rx`:
  - Ports: `clk`, `rst_n`, `RX`, `rx_data`[7:0], `rx_rdy`.
  - Contains the synchronizer, the receiver FSM and the bit and baud counters.
- The top level holds the pairing FSM, `hi_byte`, `cmd`, `cmd_rdy` and the optional timeout counter.

## Test plan
- CommMaster sends 16'h5555 → one cycle after the second `rx_rdy`, `cmd` = 16'h5555 and `cmd_rdy` = 1; `cmd` holds across 10 idle bit-times.
- 16'hFFFF, then `clr_cmd_rdy` pulse, then 16'h0000:
  - `cmd_rdy` drops the cycle after the clear.
  - `cmd_rdy` stays 0 when the high byte arrives.
  - After the second command, `cmd` = 16'h0000 and `cmd_rdy` = 1.
- `clr_cmd_rdy` in the same cycle as low-byte completion of 16'hAAAA → `cmd_rdy` = 1 and `cmd` = 16'hAAAA.
- High byte 8'h00, then a frame with stop bit 0, then 8'h2D → framed byte ignored; `cmd` = 16'h002D.
- `rst_n` low during bit 4 of the high byte of 16'h001E:
  - Outputs are 0 immediately.
  - A clean resend after release yields `cmd` = 16'h001E.
- With `CMD_BYTE_TIMEOUT_EN`: send high byte 8'h12, wait 25 bit-times, then send 8'h34 and 8'h56 → `cmd` = 16'h3456 (8'h12 discarded).
